// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle between a scanned 7-segment display and its reader.
// SEG7_DP_EN adds the decimal-point input and the per-digit dp result.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   blank_out;
  logic [NUM_DIGITS-1:0]   err_out;
  logic                    frame_valid;
`ifdef SEG7_DP_EN
  logic                    dp_in;
  logic [NUM_DIGITS-1:0]   dp_out;

  modport master (
    output seg_in, an_in, dp_in, clear,
    input  bcd_out, blank_out, err_out, dp_out, frame_valid
  );
  modport slave (
    input  seg_in, an_in, dp_in, clear,
    output bcd_out, blank_out, err_out, dp_out, frame_valid
  );
`else
  modport master (
    output seg_in, an_in, clear,
    input  bcd_out, blank_out, err_out, frame_valid
  );
  modport slave (
    input  seg_in, an_in, clear,
    output bcd_out, blank_out, err_out, frame_valid
  );
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a scanned active-low 7-segment display, debounces each digit slot and decodes it to BCD.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  seg7_scan_decoder_if.slave bus
);

`ifdef SEG7_DP_EN
  localparam int SW = NUM_DIGITS + 8;
`else
  localparam int SW = NUM_DIGITS + 7;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] seg);
    dec_t r;
    r = '{bcd: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg)
      7'b0000001: r.bcd = 4'd0;
      7'b1001111: r.bcd = 4'd1;
      7'b0010010: r.bcd = 4'd2;
      7'b0000110: r.bcd = 4'd3;
      7'b1001100: r.bcd = 4'd4;
      7'b0100100: r.bcd = 4'd5;
      7'b0100000: r.bcd = 4'd6;
      7'b0001111: r.bcd = 4'd7;
      7'b0000000: r.bcd = 4'd8;
      7'b0000100: r.bcd = 4'd9;
      7'b1111111: r.blank = 1'b1;
      default: begin
        r.bcd = 4'hF;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

  logic [SW-1:0]           pins;
  logic [SW-1:0]           sample_q;
  logic [SW-1:0]           prev_q;
  logic [7:0]              cnt_q, cnt_d;
  logic                    committed_q, committed_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    frame_q, frame_d;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic [3:0]              low_cnt;
  logic                    slot;
  logic                    same;
  logic                    commit;
  dec_t                    dec;
  logic [NUM_DIGITS-1:0]   seen_hit;

`ifdef SEG7_DP_EN
  assign pins = {bus.an_in, bus.dp_in, bus.seg_in};
`else
  assign pins = {bus.an_in, bus.seg_in};
`endif

  assign an_s     = sample_q[SW-1 -: NUM_DIGITS];
  assign seg_s    = sample_q[6:0];
  assign same     = (sample_q == prev_q);
  assign slot     = (low_cnt == 4'd1);
  assign dec      = decode(seg_s);
  assign seen_hit = seen_q | ~an_s;

  // A slot is a sample with exactly one digit enable low; anything else is a gap.
  always_comb begin
    low_cnt = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_s[k]) low_cnt = low_cnt + 4'd1;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    committed_d = committed_q;
    seen_d      = seen_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    err_d       = err_q;
    frame_d     = 1'b0;
    commit      = 1'b0;
`ifdef SEG7_DP_EN
    dp_d        = dp_q;
`endif

    if (same && slot) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
    end else begin
      cnt_d = slot ? 8'd1 : 8'd0;
    end
    if (!same) committed_d = 1'b0;

    // Saturated counter plus the committed flag gives exactly one commit per run.
    commit = slot && (cnt_d == CNT_MAX) && !committed_d;

    if (commit) begin
      committed_d = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (!an_s[k]) begin
          bcd_d[4*k +: 4] = dec.bcd;
          blank_d[k]      = dec.blank;
          err_d[k]        = dec.err;
`ifdef SEG7_DP_EN
          dp_d[k]         = ~sample_q[7];
`endif
        end
      end
      if (&seen_hit) begin
        seen_d  = '0;
        frame_d = 1'b1;
      end else begin
        seen_d  = seen_hit;
      end
    end

    // Clear overrides any commit or frame completion on the same edge.
    if (bus.clear) begin
      cnt_d       = 8'd0;
      committed_d = 1'b0;
      seen_d      = '0;
      err_d       = '0;
      frame_d     = 1'b0;
      bcd_d       = bcd_q;
      blank_d     = blank_q;
`ifdef SEG7_DP_EN
      dp_d        = dp_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q    <= '1;
      prev_q      <= '1;
      cnt_q       <= 8'd0;
      committed_q <= 1'b0;
      seen_q      <= '0;
      bcd_q       <= '0;
      blank_q     <= '1;
      err_q       <= '0;
      frame_q     <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q        <= '0;
`endif
    end else begin
      sample_q    <= pins;
      prev_q      <= sample_q;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      seen_q      <= seen_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
`ifdef SEG7_DP_EN
      dp_q        <= dp_d;
`endif
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.blank_out   = blank_q;
  assign bus.err_out     = err_q;
  assign bus.frame_valid = frame_q;
`ifdef SEG7_DP_EN
  assign bus.dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (4 digits, 4-sample debounce).
// Covers the SEG7_DP_EN decimal-point path when that macro is defined.
module tb_seg7_scan_decoder;
  localparam int ND = 4;

  localparam logic [6:0] P0   = 7'b0000001;
  localparam logic [6:0] P1   = 7'b1001111;
  localparam logic [6:0] P2   = 7'b0010010;
  localparam logic [6:0] P3   = 7'b0000110;
  localparam logic [6:0] P4   = 7'b1001100;
  localparam logic [6:0] P5   = 7'b0100100;
  localparam logic [6:0] P6   = 7'b0100000;
  localparam logic [6:0] P7   = 7'b0001111;
  localparam logic [6:0] P8   = 7'b0000000;
  localparam logic [6:0] P9   = 7'b0000100;
  localparam logic [6:0] POFF = 7'b1111111;
  localparam logic [6:0] PBAD = 7'b1110110;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errs;
  int   fv_count;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_valid) fv_count <= fv_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         digit;
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.an_in  = '1;
    bus.seg_in = POFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an_in  = an;
    bus.seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] an, input logic [6:0] seg);
    hold(an, seg, 6);
    idle(1);
  endtask

  task automatic pulse_clear;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    fv_count = 0;

    tbl[0] = '{an: 4'b1110, seg: P3,   digit: 0, bcd: 4'd3, blank: 1'b0, err: 1'b0};
    tbl[1] = '{an: 4'b1101, seg: P7,   digit: 1, bcd: 4'd7, blank: 1'b0, err: 1'b0};
    tbl[2] = '{an: 4'b1011, seg: P0,   digit: 2, bcd: 4'd0, blank: 1'b0, err: 1'b0};
    tbl[3] = '{an: 4'b0111, seg: P9,   digit: 3, bcd: 4'd9, blank: 1'b0, err: 1'b0};
    tbl[4] = '{an: 4'b1110, seg: P0,   digit: 0, bcd: 4'd0, blank: 1'b0, err: 1'b0};
    tbl[5] = '{an: 4'b1101, seg: POFF, digit: 1, bcd: 4'd0, blank: 1'b1, err: 1'b0};
    tbl[6] = '{an: 4'b1011, seg: PBAD, digit: 2, bcd: 4'hF, blank: 1'b0, err: 1'b1};
    tbl[7] = '{an: 4'b0111, seg: P1,   digit: 3, bcd: 4'd1, blank: 1'b0, err: 1'b0};

    reset_n    = 1'b0;
    bus.an_in  = '1;
    bus.seg_in = POFF;
    bus.clear  = 1'b0;
`ifdef SEG7_DP_EN
    bus.dp_in  = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    chk("reset_bcd",   32'(bus.bcd_out),   32'h0000);
    chk("reset_blank", 32'(bus.blank_out), 32'hF);
    chk("reset_err",   32'(bus.err_out),   32'h0);
    chk("reset_no_fv", 32'(fv_count),      32'd0);

    // Commit latency: stable value lands on the fifth edge, not the fourth.
    hold(4'b1110, P2, 4);
    chk("lat_before_5th", 32'(bus.bcd_out[3:0]), 32'h0);
    hold(4'b1110, P2, 1);
    chk("lat_at_5th_bcd",   32'(bus.bcd_out[3:0]), 32'h2);
    chk("lat_at_5th_blank", 32'(bus.blank_out[0]), 32'h0);
    idle(2);

    hold(4'b1101, P3, 3);
    idle(5);
    chk("short_hold_bcd",   32'(bus.bcd_out),   32'h0002);
    chk("short_hold_blank", 32'(bus.blank_out), 32'hE);
    pulse_clear();

    for (int i = 0; i < 8; i++) begin
      digit(tbl[i].an, tbl[i].seg);
      chk($sformatf("vec%0d_bcd", i),   32'(bus.bcd_out[4*tbl[i].digit +: 4]), 32'(tbl[i].bcd));
      chk($sformatf("vec%0d_blank", i), 32'(bus.blank_out[tbl[i].digit]),     32'(tbl[i].blank));
      chk($sformatf("vec%0d_err", i),   32'(bus.err_out[tbl[i].digit]),       32'(tbl[i].err));
      if (i == 3) begin
        chk("frame1_bcd", 32'(bus.bcd_out), 32'h9073);
        chk("frame1_fv",  32'(fv_count),    32'd1);
      end
    end
    chk("frame2_bcd",   32'(bus.bcd_out),   32'h1F00);
    chk("frame2_blank", 32'(bus.blank_out), 32'h2);
    chk("frame2_err",   32'(bus.err_out),   32'h4);
    chk("frame2_fv",    32'(fv_count),      32'd2);

    hold(4'b1100, P8, 10);
    idle(3);
    chk("multi_low_bcd", 32'(bus.bcd_out), 32'h1F00);
    chk("multi_low_fv",  32'(fv_count),    32'd2);

    pulse_clear();
    chk("clear_err",    32'(bus.err_out),   32'h0);
    chk("clear_keeps",  32'(bus.bcd_out),   32'h1F00);
    chk("clear_blank",  32'(bus.blank_out), 32'h2);

    // Long hold commits once; a second commit of digit 0 must not count toward the frame.
    hold(4'b1110, P5, 30);
    idle(1);
    chk("long_hold_bcd", 32'(bus.bcd_out[3:0]), 32'h5);
    digit(4'b1110, P6);
    digit(4'b1101, P4);
    digit(4'b1011, P8);
    chk("recommit_no_frame", 32'(fv_count), 32'd2);
    chk("recommit_bcd",      32'(bus.bcd_out), 32'h1846);
    digit(4'b0111, P7);
    chk("frame3_fv",  32'(fv_count),    32'd3);
    chk("frame3_bcd", 32'(bus.bcd_out), 32'h7846);

    // Clear on the final digit's commit edge discards the commit and the frame.
    pulse_clear();
    digit(4'b1110, P9);
    digit(4'b1101, P0);
    digit(4'b1011, P3);
    hold(4'b0111, P8, 4);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    idle(4);
    chk("clr_commit_fv",  32'(fv_count),    32'd3);
    chk("clr_commit_bcd", 32'(bus.bcd_out), 32'h7309);
    chk("clr_commit_err", 32'(bus.err_out), 32'h0);
    digit(4'b0111, P2);
    chk("seen_cleared_fv", 32'(fv_count),    32'd3);
    chk("seen_cleared_bcd", 32'(bus.bcd_out), 32'h2309);
    digit(4'b1110, P1);
    digit(4'b1101, P1);
    digit(4'b1011, P1);
    chk("frame4_fv",  32'(fv_count),    32'd4);
    chk("frame4_bcd", 32'(bus.bcd_out), 32'h2111);

    hold(4'b1110, P0, 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_bcd",   32'(bus.bcd_out),     32'h0000);
    chk("midrst_blank", 32'(bus.blank_out),   32'hF);
    chk("midrst_fv",    32'(bus.frame_valid), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(4'b1110, P0, 3);
    idle(3);
    chk("after_rst_no_commit", 32'(bus.bcd_out),   32'h0000);
    chk("after_rst_blank",     32'(bus.blank_out), 32'hF);
    chk("after_rst_fv",        32'(fv_count),      32'd4);

`ifdef SEG7_DP_EN
    bus.dp_in = 1'b0;
    hold(4'b1110, P5, 6);
    bus.dp_in = 1'b1;
    idle(1);
    chk("dp_bcd", 32'(bus.bcd_out[3:0]), 32'h5);
    chk("dp_out", 32'(bus.dp_out[0]),    32'h1);
    chk("dp_err", 32'(bus.err_out[0]),   32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
